// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the control FSM state type, the ALU control-code constants and
// the legality check used to reject unsupported codes before execution.
package alu_arb_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // ALU control codes understood by the shared ALU
  localparam logic [3:0] CTR_ADD  = 4'd0;
  localparam logic [3:0] CTR_SLL  = 4'd1;
  localparam logic [3:0] CTR_SLT  = 4'd2;
  localparam logic [3:0] CTR_SLTU = 4'd3;
  localparam logic [3:0] CTR_XOR  = 4'd4;
  localparam logic [3:0] CTR_SRL  = 4'd5;
  localparam logic [3:0] CTR_OR   = 4'd6;
  localparam logic [3:0] CTR_AND  = 4'd7;
  localparam logic [3:0] CTR_SUB  = 4'd8;
  localparam logic [3:0] CTR_SRA  = 4'd13;
  localparam logic [3:0] CTR_LUI  = 4'd15;

  // True when the ALU implements the given control code
  function automatic logic ctr_legal(input logic [3:0] ctr);
    logic ok;
    case (ctr)
      CTR_ADD, CTR_SLL, CTR_SLT, CTR_SLTU, CTR_XOR, CTR_SRL,
      CTR_OR, CTR_AND, CTR_SUB, CTR_SRA, CTR_LUI: ok = 1'b1;
      default:                                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of all handshake and data signals around the ALU arbiter:
// two request channels, the ALU operand/result wires, the tagged response
// channel and the busy flag. slave = arbiter side, master = environment side.
interface alu_arbiter_if #(
  parameter int DATA_W = 32
);

  // Requester 0
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [3:0]        req0_ctr;

  // Requester 1
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [3:0]        req1_ctr;

  // Shared ALU
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_ctr;
  logic [DATA_W-1:0] alu_result;
  logic              alu_less;
  logic              alu_zero;

  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_less;
  logic              rsp_zero;
  logic              rsp_err;

  logic              busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctr,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctr,
    output req1_ready,
    output alu_a, alu_b, alu_ctr,
    input  alu_result, alu_less, alu_zero,
    output rsp_valid, rsp_id, rsp_result, rsp_less, rsp_zero, rsp_err,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctr,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_ctr,
    input  req1_ready,
    input  alu_a, alu_b, alu_ctr,
    output alu_result, alu_less, alu_zero,
    input  rsp_valid, rsp_id, rsp_result, rsp_less, rsp_zero, rsp_err,
    output rsp_ready,
    input  busy
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way arbiter, combinational grant plus round-robin pointer.
// Latency: grant is combinational from req; pointer updates on the accept edge.
// Backpressure: pointer moves only when 'advance' (a real handshake) is high.
// Ports: clk, rst_n, req[1:0] (valid requests), advance (grant taken), grant (winner id).
// Macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties, no pointer register.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  // Requester 1 only wins when requester 0 is idle
  assign grant = !req[0] && req[1];

  // Clock, reset and advance have no function in the fixed-priority build
  logic unused_fixed;
  assign unused_fixed = &{1'b0, clk, rst_n, advance};

`else

  // Names the requester that wins the next tie
  logic ptr_q;

  // Tie goes to the pointer; otherwise the single valid requester wins.
  // With nothing valid the value is irrelevant since advance stays low.
  assign grant = (req[0] && req[1]) ? ptr_q : req[1];

  // After every grant, favour the other requester, even if it was idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (advance) begin
      ptr_q <= !grant;
    end
  end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters, round-robin.
// Latency: accept in cycle T, rsp_valid in T+2; one op per 3 cycles at best.
// Backpressure: holds the response until rsp_ready; no accept while busy.
// Ports: clk, rst_n (async, active-low), bus (alu_arbiter_if.slave) carrying
//   req0/req1 valid-ready channels, alu_a/alu_b/alu_ctr out, alu_result/
//   alu_less/alu_zero in, the tagged rsp channel and busy.
// Macro ALU_ARB_FIXED_PRIO_EN (in rr_arb2): fixed priority to requester 0.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  state_t state_q, state_d;

  logic              grant;
  logic              accept;
  logic              ready0;
  logic              ready1;
  logic              rsp_valid;

  // Winning request, selected by grant
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [3:0]        sel_ctr;
  logic              sel_legal;

  // Operation registers driven to the ALU
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [3:0]        alu_ctr_q;
  logic              id_q;
  logic              err_q;

  // Captured response
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_less_q;
  logic              rsp_zero_q;
  logic              rsp_err_q;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({bus.req1_valid, bus.req0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    sel_a     = grant ? bus.req1_a   : bus.req0_a;
    sel_b     = grant ? bus.req1_b   : bus.req0_b;
    sel_ctr   = grant ? bus.req1_ctr : bus.req0_ctr;
    sel_legal = ctr_legal(sel_ctr);
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ready0    = 1'b0;
    ready1    = 1'b0;
    accept    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // rst_n gating keeps ready low while reset is asserted, since the
        // state register already reads IDLE during reset
        ready0 = rst_n && bus.req0_valid && !grant;
        ready1 = rst_n && bus.req1_valid &&  grant;
        accept = ready0 || ready1;
        if (accept) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Operation registers: loaded only at the request handshake
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_ctr_q <= CTR_ADD;
      id_q      <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept) begin
      alu_a_q   <= sel_a;
      alu_b_q   <= sel_b;
      // Illegal codes never reach the ALU; it idles on ADD for that op
      alu_ctr_q <= sel_legal ? sel_ctr : CTR_ADD;
      id_q      <= grant;
      err_q     <= !sel_legal;
    end
  end

  // ---------------------------------------------------------------------
  // Response capture at the end of EXEC; held through RESP
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q <= '0;
      rsp_less_q   <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else if (state_q == EXEC) begin
      // A rejected op reports only the error flag, all ALU outputs zeroed
      rsp_result_q <= err_q ? '0   : bus.alu_result;
      rsp_less_q   <= err_q ? 1'b0 : bus.alu_less;
      rsp_zero_q   <= err_q ? 1'b0 : bus.alu_zero;
      rsp_err_q    <= err_q;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_ctr    = alu_ctr_q;
  assign bus.rsp_valid  = rsp_valid;
  // id_q is stable from accept through the response handshake
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_less   = rsp_less_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios then random traffic.
// Expected responses are queued at acceptance and checked by a separate monitor.
module tb_alu_arbiter;

  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(DW)) bus ();

  alu_arbiter #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------------------------------------------------------------
  // Reference ALU arithmetic (also serves as the external ALU)
  // ---------------------------------------------------------------------
  function automatic logic [31:0] alu_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    logic [31:0] r;
    case (c)
      4'd0:    r = a + b;
      4'd1:    r = a << b[4:0];
      4'd2:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    r = (a < b) ? 32'd1 : 32'd0;
      4'd4:    r = a ^ b;
      4'd5:    r = a >> b[4:0];
      4'd6:    r = a | b;
      4'd7:    r = a & b;
      4'd8:    r = a - b;
      4'd13:   r = 32'($signed(a) >>> b[4:0]);
      4'd15:   r = b;
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  function automatic logic alu_lt(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] c);
    return (c == 4'd3) ? (a < b) : ($signed(a) < $signed(b));
  endfunction

  function automatic bit is_legal(input logic [3:0] c);
    return (c <= 4'd8) || (c == 4'd13) || (c == 4'd15);
  endfunction

  always_comb begin
    bus.alu_result = alu_res(bus.alu_a, bus.alu_b, bus.alu_ctr);
    bus.alu_less   = alu_lt(bus.alu_a, bus.alu_b, bus.alu_ctr);
    bus.alu_zero   = (alu_res(bus.alu_a, bus.alu_b, bus.alu_ctr) == 32'd0);
  end

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  typedef struct {
    logic        id;
    logic [31:0] result;
    logic        less;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented response against the queue head;
  // re-checking each cycle also proves the outputs hold under backpressure.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
        end else begin
          e = exp_q[0];
          check("rsp_id",     {31'd0, bus.rsp_id},   {31'd0, e.id});
          check("rsp_result", bus.rsp_result,        e.result);
          check("rsp_less",   {31'd0, bus.rsp_less}, {31'd0, e.less});
          check("rsp_zero",   {31'd0, bus.rsp_zero}, {31'd0, e.zero});
          check("rsp_err",    {31'd0, bus.rsp_err},  {31'd0, e.err});
          if (bus.rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Transaction-level model: an op is outstanding from acceptance until
  // its response handshake; the response shows two cycles after acceptance.
  // ---------------------------------------------------------------------
  int          cyc        = 0;
  bit          m_pending  = 1'b0;
  int          m_rsp_at   = 0;
  bit          m_ptr      = 1'b0;
  logic [31:0] m_exp_a, m_exp_b;
  logic [3:0]  m_exp_ctr;

  task automatic cycle(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] c0,
                       input bit v1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic [3:0] c1, input bit rr);
    bit   g, e0, e1;
    exp_t e;
    logic [31:0] xa, xb;
    logic [3:0]  xc;
    @(posedge clk);
    #1;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_ctr = c0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_ctr = c1;
    bus.rsp_ready  = rr;
    @(negedge clk);
    cyc++;
    g  = 1'b0;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!m_pending) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = (v0 && v1) ? 1'b0 : v1;
`else
      g = (v0 && v1) ? m_ptr : v1;
`endif
      e0 = v0 && !g;
      e1 = v1 && g;
    end
    check("req0_ready", {31'd0, bus.req0_ready}, {31'd0, e0});
    check("req1_ready", {31'd0, bus.req1_ready}, {31'd0, e1});
    check("busy",       {31'd0, bus.busy},       {31'd0, m_pending});
    check("rsp_valid",  {31'd0, bus.rsp_valid},  {31'd0, (m_pending && cyc >= m_rsp_at)});
    if (m_pending && cyc == m_rsp_at - 1) begin
      check("exec_alu_a",   bus.alu_a,            m_exp_a);
      check("exec_alu_b",   bus.alu_b,            m_exp_b);
      check("exec_alu_ctr", {28'd0, bus.alu_ctr}, {28'd0, m_exp_ctr});
    end
    if (!m_pending && (e0 || e1)) begin
      xa = g ? a1 : a0;
      xb = g ? b1 : b0;
      xc = g ? c1 : c0;
      e.id = g;
      if (is_legal(xc)) begin
        e.result = alu_res(xa, xb, xc);
        e.less   = alu_lt(xa, xb, xc);
        e.zero   = (e.result == 32'd0);
        e.err    = 1'b0;
        m_exp_ctr = xc;
      end else begin
        e.result = 32'd0;
        e.less   = 1'b0;
        e.zero   = 1'b0;
        e.err    = 1'b1;
        m_exp_ctr = 4'd0;
      end
      m_exp_a = xa;
      m_exp_b = xb;
      exp_q.push_back(e);
      m_pending = 1'b1;
      m_rsp_at  = cyc + 2;
      m_ptr     = !g;
    end else if (m_pending && cyc >= m_rsp_at && rr) begin
      m_pending = 1'b0;
    end
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, rr);
  endtask

  // One-cycle reset pulse, asserted just after a rising edge.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    check("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
    check("rst_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    check("rst_busy",       {31'd0, bus.busy},       32'd0);
    check("rst_rsp_valid",  {31'd0, bus.rsp_valid},  32'd0);
    check("rst_alu_ctr",    {28'd0, bus.alu_ctr},    32'd0);
    exp_q.delete();
    m_pending = 1'b0;
    m_ptr     = 1'b0;
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int guard;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctr = '0;
    bus.req1_valid = 1'b1; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctr = '0;
    bus.rsp_ready  = 1'b0;
    #1 rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_alu_a",      bus.alu_a,                 32'd0);
    check("reset_alu_b",      bus.alu_b,                 32'd0);
    check("reset_alu_ctr",    {28'd0, bus.alu_ctr},      32'd0);
    check("reset_rsp_valid",  {31'd0, bus.rsp_valid},    32'd0);
    check("reset_rsp_result", bus.rsp_result,            32'd0);
    check("reset_rsp_flags",  {28'd0, bus.rsp_id, bus.rsp_less, bus.rsp_zero, bus.rsp_err}, 32'd0);
    check("reset_busy",       {31'd0, bus.busy},         32'd0);
    check("reset_req0_ready", {31'd0, bus.req0_ready},   32'd0);
    check("reset_req1_ready", {31'd0, bus.req1_ready},   32'd0);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;

    // Single op: 5 - 3 on requester 0
    cycle(1'b1, 32'd5, 32'd3, 4'd8, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    idle(4, 1'b1);

    // Contention: both valid continuously
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 32'd1, 32'd1, 4'd0, 1'b1, 32'd2, 32'd2, 4'd0, 1'b1);
    idle(3, 1'b1);

    // Backpressure: response held for many cycles while both keep requesting
    cycle(1'b1, 32'd7, 32'd9, 4'd6, 1'b1, 32'd3, 32'd3, 4'd8, 1'b0);
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 32'd7, 32'd9, 4'd6, 1'b1, 32'd3, 32'd3, 4'd8, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'd7, 32'd9, 4'd6, 1'b1, 32'd3, 32'd3, 4'd8, 1'b1);
    idle(3, 1'b1);

    // Signed vs unsigned compare on requester 1
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'd2, 1'b1);
    idle(3, 1'b1);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'd3, 1'b1);
    idle(3, 1'b1);

    // Illegal control code
    cycle(1'b1, 32'd4, 32'd4, 4'd9, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    idle(3, 1'b1);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'd1, 32'd2, 4'd14, 1'b1);
    idle(3, 1'b1);

    // Reset during EXEC discards the op and returns the pointer to 0
    cycle(1'b1, 32'd11, 32'd22, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    do_reset();
    idle(3, 1'b1);
    cycle(1'b1, 32'd10, 32'd20, 4'd0, 1'b1, 32'd30, 32'd40, 4'd0, 1'b1);
    idle(3, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 40),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0));
    end

    // Drain
    guard = 0;
    while ((m_pending || exp_q.size() != 0) && guard < 20) begin
      idle(1, 1'b1);
      guard++;
    end
    check("drain_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
